// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types for the DRAM bus arbiter: packet type encoding, FSM states, requester id.
package mem_bus_arb_pkg;

  localparam int SRC_W_DEF = 3;

  // Encodings 2'b00 and 2'b11 are illegal on the bus and are rejected at arbitration.
  typedef enum logic [1:0] {
    bus_read_data  = 2'b01,
    bus_write_data = 2'b10
  } bus_packet_type_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  typedef logic [SRC_W_DEF-1:0] requester_id_t;

  function automatic logic is_known_type(input logic [1:0] t);
    return (t == bus_read_data) || (t == bus_write_data);
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request bit at or after ptr, wrapping; purely combinational.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   idx,
  output logic               vld
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    cand  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = SRC_W'(cand);
        vld         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter serialising NUM_REQ masters onto one DRAM port; request to mem_req_valid 1 cycle,
// mem_req_ready to req_ready 1 cycle, response to rsp_valid 1 cycle; a read holds the bus until its response.
module memory_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*2-1:0]      req_type,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_payload,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [1:0]                mem_req_type,
  output logic [ADDR_W-1:0]         mem_req_address,
  output logic [DATA_W-1:0]         mem_req_payload,
  output logic [SRC_W-1:0]          mem_req_source,
  input  logic                      mem_rsp_valid,
  input  logic [SRC_W-1:0]          mem_rsp_source,
  input  logic [DATA_W-1:0]         mem_rsp_payload,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_payload,
  output logic                      protocol_error
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_ISSUE    = ISSUE;
  localparam logic [1:0] S_WAIT_RSP = WAIT_RSP;

  logic [1:0]         state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [1:0]         pick_type;
  logic [NUM_REQ-1:0] cur_onehot;

  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // A requester whose req_ready is high this cycle still shows valid; keep it out of the next pick.
  rr_priority_picker #(
    .NUM_REQ(NUM_REQ),
    .SRC_W  (SRC_W)
  ) u_picker (
    .req  (req_valid & ~req_ready),
    .ptr  (rr_ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign pick_type  = req_type[int'(pick_idx)*2 +: 2];
  assign cur_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << mem_req_source;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      req_ready       <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_type    <= '0;
      mem_req_address <= '0;
      mem_req_payload <= '0;
      mem_req_source  <= '0;
      rsp_valid       <= '0;
      rsp_payload     <= '0;
      protocol_error  <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      if (mem_rsp_valid && state != S_WAIT_RSP) begin
        protocol_error <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            if (is_known_type(pick_type)) begin
              mem_req_valid   <= 1'b1;
              mem_req_type    <= pick_type;
              mem_req_address <= req_address[int'(pick_idx)*ADDR_W +: ADDR_W];
              mem_req_payload <= req_payload[int'(pick_idx)*DATA_W +: DATA_W];
              mem_req_source  <= pick_idx;
              state           <= S_ISSUE;
            end else begin
              req_ready      <= pick_grant;
              protocol_error <= 1'b1;
              rr_ptr         <= next_ptr(pick_idx);
            end
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            req_ready     <= cur_onehot;
            rr_ptr        <= next_ptr(mem_req_source);
            state         <= (mem_req_type == bus_read_data) ? S_WAIT_RSP : S_IDLE;
          end
        end
        S_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_source == mem_req_source) begin
              rsp_payload <= mem_rsp_payload;
              rsp_valid   <= cur_onehot;
              state       <= S_IDLE;
            end else begin
              protocol_error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: cycle-by-cycle vector table plus hand sequences for stall and reset.
module tb_memory_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 3;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*2-1:0]      req_type;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_payload;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [1:0]                mem_req_type;
  logic [ADDR_W-1:0]         mem_req_address;
  logic [DATA_W-1:0]         mem_req_payload;
  logic [SRC_W-1:0]          mem_req_source;
  logic                      mem_rsp_valid;
  logic [SRC_W-1:0]          mem_rsp_source;
  logic [DATA_W-1:0]         mem_rsp_payload;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_payload;
  logic                      protocol_error;

  memory_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .SRC_W(SRC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_type(req_type), .req_address(req_address),
    .req_payload(req_payload), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_type(mem_req_type), .mem_req_address(mem_req_address),
    .mem_req_payload(mem_req_payload), .mem_req_source(mem_req_source),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_source(mem_rsp_source),
    .mem_rsp_payload(mem_rsp_payload),
    .rsp_valid(rsp_valid), .rsp_payload(rsp_payload), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  typedef struct {
    logic [3:0]  rv;
    logic [7:0]  rt;
    logic        mrdy;
    logic        rspv;
    logic [2:0]  rsps;
    logic [63:0] rspd;
    logic        emv;
    logic [2:0]  esrc;
    logic [1:0]  etype;
    logic [3:0]  erdy;
    logic [3:0]  ersp;
    logic [63:0] erpd;
    logic        eerr;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];
  logic [63:0] addr_tbl [NUM_REQ];
  logic [63:0] pay_tbl  [NUM_REQ];
  int total = 0;
  int bad   = 0;

  function automatic vec_t v(input logic [3:0] rv, input logic [7:0] rt, input logic rspv,
                             input logic [2:0] rsps, input logic [63:0] rspd, input logic emv,
                             input logic [2:0] esrc, input logic [1:0] etype, input logic [3:0] erdy,
                             input logic [3:0] ersp, input logic [63:0] erpd, input logic eerr);
    vec_t r;
    r.rv = rv; r.rt = rt; r.mrdy = 1'b1; r.rspv = rspv; r.rsps = rsps; r.rspd = rspd;
    r.emv = emv; r.esrc = esrc; r.etype = etype; r.erdy = erdy; r.ersp = ersp;
    r.erpd = erpd; r.eerr = eerr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({nm, " mem_req_addr"}, mem_req_address, 64'd0);
    chk({nm, " mem_req_source"}, 64'(mem_req_source), 64'd0);
    chk({nm, " req_ready"}, 64'(req_ready), 64'd0);
    chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, " rsp_payload"}, rsp_payload, 64'd0);
    chk({nm, " protocol_error"}, 64'(protocol_error), 64'd0);
  endtask

  initial begin
    addr_tbl[0] = 64'h10;  addr_tbl[1] = 64'h100; addr_tbl[2] = 64'h40; addr_tbl[3] = 64'h300;
    pay_tbl[0]  = 64'hA0;  pay_tbl[1]  = 64'hA1;  pay_tbl[2]  = 64'h1122334455667788;
    pay_tbl[3]  = 64'hA3;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_address[i*ADDR_W +: ADDR_W] = addr_tbl[i];
      req_payload[i*DATA_W +: DATA_W] = pay_tbl[i];
    end

    // round robin over four continuous writers, starting at ptr 0
    tbl[0]  = v(4'b1111, 8'hAA, 0, 0, 0, 1, 0, WR, 4'b0000, 0, 0, 0);
    tbl[1]  = v(4'b1111, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b0001, 0, 0, 0);
    tbl[2]  = v(4'b1111, 8'hAA, 0, 0, 0, 1, 1, WR, 4'b0000, 0, 0, 0);
    tbl[3]  = v(4'b1111, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b0010, 0, 0, 0);
    tbl[4]  = v(4'b1111, 8'hAA, 0, 0, 0, 1, 2, WR, 4'b0000, 0, 0, 0);
    tbl[5]  = v(4'b1111, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b0100, 0, 0, 0);
    tbl[6]  = v(4'b1111, 8'hAA, 0, 0, 0, 1, 3, WR, 4'b0000, 0, 0, 0);
    tbl[7]  = v(4'b1111, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b1000, 0, 0, 0);
    tbl[8]  = v(4'b1111, 8'hAA, 0, 0, 0, 1, 0, WR, 4'b0000, 0, 0, 0);
    tbl[9]  = v(4'b1111, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b0001, 0, 0, 0);
    tbl[10] = v(4'b0000, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 0, 0);
    // single write from req 2; it is still visible while its req_ready is up
    tbl[11] = v(4'b0100, 8'hAA, 0, 0, 0, 1, 2, WR, 4'b0000, 0, 0, 0);
    tbl[12] = v(4'b0100, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b0100, 0, 0, 0);
    tbl[13] = v(4'b0100, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 0, 0);
    tbl[14] = v(4'b0000, 8'hAA, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 0, 0);
    // read from req 1 with req 0 waiting behind it; response 5 cycles after handshake
    tbl[15] = v(4'b0010, 8'hA6, 0, 0, 0, 1, 1, RD, 4'b0000, 0, 0, 0);
    tbl[16] = v(4'b0011, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0010, 0, 0, 0);
    tbl[17] = v(4'b0001, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 0, 0);
    tbl[18] = v(4'b0001, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 0, 0);
    tbl[19] = v(4'b0001, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 0, 0);
    tbl[20] = v(4'b0001, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 0, 0);
    tbl[21] = v(4'b0001, 8'hA6, 1, 1, 64'hDEADBEEF, 0, 0, WR, 4'b0000, 4'b0010, 64'hDEADBEEF, 0);
    tbl[22] = v(4'b0001, 8'hA6, 0, 0, 0, 1, 0, WR, 4'b0000, 0, 64'hDEADBEEF, 0);
    tbl[23] = v(4'b0001, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0001, 0, 64'hDEADBEEF, 0);
    tbl[24] = v(4'b0000, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 64'hDEADBEEF, 0);
    // wrong-source response during a pending read is dropped and flagged
    tbl[25] = v(4'b0010, 8'hA6, 0, 0, 0, 1, 1, RD, 4'b0000, 0, 64'hDEADBEEF, 0);
    tbl[26] = v(4'b0010, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0010, 0, 64'hDEADBEEF, 0);
    tbl[27] = v(4'b0000, 8'hA6, 1, 3, 64'h1234, 0, 0, WR, 4'b0000, 0, 64'hDEADBEEF, 1);
    tbl[28] = v(4'b0000, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 64'hDEADBEEF, 1);
    tbl[29] = v(4'b0000, 8'hA6, 1, 1, 64'h55AA, 0, 0, WR, 4'b0000, 4'b0010, 64'h55AA, 1);
    tbl[30] = v(4'b0000, 8'hA6, 0, 0, 0, 0, 0, WR, 4'b0000, 0, 64'h55AA, 1);

    reset = 1'b1; req_valid = '0; req_type = 8'hAA; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_source = '0; mem_rsp_payload = '0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      req_valid = tbl[i].rv; req_type = tbl[i].rt; mem_req_ready = tbl[i].mrdy;
      mem_rsp_valid = tbl[i].rspv; mem_rsp_source = tbl[i].rsps; mem_rsp_payload = tbl[i].rspd;
      step();
      chk($sformatf("row%0d mem_req_valid", i), 64'(mem_req_valid), 64'(tbl[i].emv));
      if (tbl[i].emv) begin
        chk($sformatf("row%0d mem_req_source", i), 64'(mem_req_source), 64'(tbl[i].esrc));
        chk($sformatf("row%0d mem_req_type", i), 64'(mem_req_type), 64'(tbl[i].etype));
        chk($sformatf("row%0d mem_req_address", i), mem_req_address, addr_tbl[tbl[i].esrc]);
        chk($sformatf("row%0d mem_req_payload", i), mem_req_payload, pay_tbl[tbl[i].esrc]);
      end
      chk($sformatf("row%0d req_ready", i), 64'(req_ready), 64'(tbl[i].erdy));
      chk($sformatf("row%0d rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].ersp));
      chk($sformatf("row%0d rsp_payload", i), rsp_payload, tbl[i].erpd);
      chk($sformatf("row%0d protocol_error", i), 64'(protocol_error), 64'(tbl[i].eerr));
    end
    mem_rsp_valid = 1'b0;

    // stall: req 3 write held off for 10 cycles (rr_ptr is 2 here)
    req_valid = 4'b1000; req_type = 8'hAA; mem_req_ready = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall%0d valid", c), 64'(mem_req_valid), 64'd1);
      chk($sformatf("stall%0d source", c), 64'(mem_req_source), 64'd3);
      chk($sformatf("stall%0d address", c), mem_req_address, 64'h300);
      chk($sformatf("stall%0d payload", c), mem_req_payload, 64'hA3);
      chk($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'd0);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    chk("stall handshake req_ready", 64'(req_ready), 64'b1000);
    chk("stall handshake valid", 64'(mem_req_valid), 64'd0);
    req_valid = '0;
    step();
    chk("stall post req_ready", 64'(req_ready), 64'd0);

    // reset while a read from req 0 is outstanding
    req_valid = 4'b0001; req_type = 8'hA9;
    step();
    chk("rdrst issue source", 64'(mem_req_source), 64'd0);
    chk("rdrst issue type", 64'(mem_req_type), 64'(RD));
    step();
    chk("rdrst req_ready", 64'(req_ready), 64'b0001);
    req_valid = '0;
    step();
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async reset in WAIT_RSP");
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1000; req_type = 8'hAA;
    step();
    chk("post-reset grant valid", 64'(mem_req_valid), 64'd1);
    chk("post-reset grant source", 64'(mem_req_source), 64'd3);
    step();
    chk("post-reset req_ready", 64'(req_ready), 64'b1000);
    req_valid = '0; mem_rsp_valid = 1'b1; mem_rsp_source = 3'd0; mem_rsp_payload = 64'h77;
    step();
    mem_rsp_valid = 1'b0;
    chk("late rsp error", 64'(protocol_error), 64'd1);
    chk("late rsp dropped", 64'(rsp_valid), 64'd0);

    // illegal packet type: consumed, flagged, pointer advances past it
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("second reset error clear", 64'(protocol_error), 64'd0);
    req_valid = 4'b0010; req_type = 8'hA2;
    step();
    chk("bad type req_ready", 64'(req_ready), 64'b0010);
    chk("bad type error", 64'(protocol_error), 64'd1);
    chk("bad type not forwarded", 64'(mem_req_valid), 64'd0);
    req_valid = '0;
    step();
    chk("bad type pulse one cycle", 64'(req_ready), 64'd0);
    req_valid = 4'b0110; req_type = 8'hAA;
    step();
    chk("ptr advanced past bad", 64'(mem_req_source), 64'd2);
    chk("ptr advanced valid", 64'(mem_req_valid), 64'd1);
    // reset during ISSUE drops mem_req_valid without a clock edge
    #2 reset = 1'b1;
    #1;
    chk("async reset in ISSUE valid", 64'(mem_req_valid), 64'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Shares the single DRAM memory-bus port between `NUM_REQ` requesters (core/cache bus masters) with round-robin fairness. It sequences exactly one transaction into DRAM at a time: a write is fire-and-forget, while a read holds the bus until the matching response returns. It then routes the read response back to the issuing requester using the packet `source` field. It sits between the per-core bus masters and the DRAM model/controller.

## Interface

One clock; reset is asynchronous and active-high.

**Parameters**

- `NUM_REQ`, 4: number of requesters (2..8).
- `SRC_W`, 3: width of the `source` id; must satisfy `NUM_REQ <= 2**SRC_W`.
- `ADDR_W`, 64: bus address width.
- `DATA_W`, 64: `bus_packet_payload_t` width (8 bytes).

**Ports**

- `clk` in 1: clock.
- `reset` in 1: async active-high reset.
- `req_valid` in `NUM_REQ`: requester i has a packet.
- `req_type` in `NUM_REQ*2`: `bus_packet_type_t` per requester.
- `req_address` in `NUM_REQ*ADDR_W`: per-requester address.
- `req_payload` in `NUM_REQ*DATA_W`: per-requester write data.
- `req_ready` out `NUM_REQ`: one-hot pulse; requester i's packet is consumed.
- `mem_req_valid` out 1: packet presented to DRAM.
- `mem_req_ready` in 1: DRAM accepts the packet.
- `mem_req_type` out 2: type of the granted packet.
- `mem_req_address` out `ADDR_W`: address of the granted packet.
- `mem_req_payload` out `DATA_W`: payload of the granted packet.
- `mem_req_source` out `SRC_W`: granted requester index.
- `mem_rsp_valid` in 1: DRAM read response.
- `mem_rsp_source` in `SRC_W`: source of the DRAM read response.
- `mem_rsp_payload` in `DATA_W`: read data.
- `rsp_valid` out `NUM_REQ`: one-hot read-response strobe.
- `rsp_payload` out `DATA_W`: read data, shared by all requesters.
- `protocol_error` out 1: sticky error flag.

## Operation

**States**

- **IDLE**
  - If any `req_valid` is set: pick the winner by round-robin starting at `rr_ptr`, latch its type/address/payload/index, and go to ISSUE.
  - If the winner's type is neither `bus_read_data` nor `bus_write_data`: pulse its `req_ready`, set `protocol_error`, advance `rr_ptr`, and stay in IDLE. The packet is not forwarded.
- **ISSUE**
  - `mem_req_valid` = 1 with the latched fields, held stable until `mem_req_ready`.
  - On handshake: pulse `req_ready[winner]`, and set `rr_ptr` = (winner+1) mod `NUM_REQ`.
  - Then go to IDLE if the packet was a write, or to WAIT_RSP if it was a read.
- **WAIT_RSP**
  - On `mem_rsp_valid` with `mem_rsp_source` == latched index: register `rsp_payload`, pulse `rsp_valid[index]`, and go to IDLE.
  - On `mem_rsp_valid` with a mismatched source: drop the response, set `protocol_error`, and stay in WAIT_RSP.
  - There is no timeout.

**Arbitration and error rules**

- Requests are not sampled outside IDLE. A requester holds `req_valid` and its fields stable until it sees `req_ready`.
- `mem_rsp_valid` while in IDLE or ISSUE is dropped and sets `protocol_error`.
- `protocol_error` is cleared only by `reset`.
- The round-robin search wraps from `NUM_REQ-1` to 0. A requester raising `req_valid` in the same cycle as a grant competes in the next IDLE.

## Timing

**Reset values**

- State = IDLE, `rr_ptr` = 0.
- All outputs = 0: `mem_req_*`, `req_ready`, `rsp_valid`, `rsp_payload`, `protocol_error`.

**Latencies**

- `req_valid` sampled in IDLE at cycle t gives `mem_req_valid` = 1 at t+1.
- `mem_req_ready` at cycle h gives `req_ready[i]` = 1 during h+1, for exactly one cycle.
- `mem_rsp_valid` at cycle r gives `rsp_valid[i]` and `rsp_payload` at r+1, for exactly one cycle.

**Throughput**

- Back-to-back writes with `mem_req_ready` held high: one packet every 2 cycles (ISSUE, IDLE).
- Read occupancy: 2 cycles plus the DRAM read latency.

**Reset mid-operation**

- The transaction is abandoned and `mem_req_valid` drops immediately (async).
- A late DRAM response arriving after reset is seen in IDLE: it is dropped and flags `protocol_error`. The bench must accept this behaviour.

## Structure

- Shared package `mem_bus_arb_pkg` holds:
  - `bus_packet_type_t` (`bus_read_data`, `bus_write_data`), reused from the bus package where one exists;
  - `arb_state_t` {IDLE, ISSUE, WAIT_RSP};
  - `requester_id_t` (`SRC_W` bits).
- One sub-module, `rr_priority_picker`: combinational; takes `NUM_REQ` request bits and `rr_ptr`, and returns a one-hot grant plus its index and a valid bit.
- Registers and the FSM live in `memory_bus_arbiter`.

## Test plan

- Single write from req 2 (addr 0x40, payload 0x1122334455667788) with `mem_req_ready` = 1 → `mem_req_valid` 1 cycle after request; `mem_req_source` = 2; `req_ready[2]` pulses once; back in IDLE 2 cycles after the request.
- All 4 requesters hold writes continuously → grants in order 0,1,2,3,0 with `rr_ptr` wrapping; no requester is granted twice in a row while others wait.
- Read from req 1 at addr 0x100; DRAM replies after 5 cycles with source 1, payload 0xDEADBEEF → `rsp_valid` = 0b0010 exactly 1 cycle after the response; `rsp_payload` = 0xDEADBEEF; no new `mem_req_valid` before then even with req 0 pending.
- During a pending read (source 1), inject a response with source 3 → dropped, `protocol_error` = 1 and stays set; the later source-1 response completes normally.
- `mem_req_ready` held low for 10 cycles → `mem_req_*` fields stay stable throughout and no `req_ready` pulses until the handshake.
- Assert `reset` while in WAIT_RSP → all outputs 0 asynchronously; after release, a req 3 write is granted first (`rr_ptr` = 0 scan) and completes normally.
